palette_sched: RTL

//   Drives the palette-select input of the CGA palette mapper.

---
 rtl/palette_sched.sv | 94 +++++++++
 1 files changed

// File: rtl/palette_sched.sv
// Palette scheduler for the CGA palette mapper.
// Commands arrive over a valid/ready port and take effect only on a vsync rise.
//
// Ports:
//   i_clk, i_rst            pixel clock, async active-high reset
//   i_vsync                 vsync level (i_clk domain)
//   i_wr_valid/o_wr_ready   command handshake
//   i_wr_cmd, i_wr_period   command (00 pal0, 01 pal1, 10 toggle, 11 load period)
//   o_palette               palette select to mapper
//   o_pending               command latched, waiting for a frame boundary
//   o_frame_tick            one-cycle pulse after each frame boundary
module palette_sched #(
   parameter int   PERIOD_W    = 6,
   parameter logic DEFAULT_PAL = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_vsync,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [1:0]          i_wr_cmd,
   input  logic [PERIOD_W-1:0] i_wr_period,
   output logic                o_palette,
   output logic                o_pending,
   output logic                o_frame_tick
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [0:0]          state;
   logic                vs_q;
   logic                fb;
   logic                accept;
   logic [1:0]          pend_cmd;
   logic [PERIOD_W-1:0] pend_per;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] frame_cnt;

   assign fb         = i_vsync & ~vs_q;
   assign o_wr_ready = (state == IDLE);
   assign o_pending  = (state == PEND);
   assign accept     = i_wr_valid & o_wr_ready;

   // vs_q resets high so a vsync already high at release is not an edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         vs_q         <= 1'b1;
         pend_cmd     <= 2'b00;
         pend_per     <= '0;
         period       <= '0;
         frame_cnt    <= '0;
         o_palette    <= DEFAULT_PAL;
         o_frame_tick <= 1'b0;
      end else begin
         vs_q         <= i_vsync;
         o_frame_tick <= fb;
         case (state)
            IDLE: begin
               // A command accepted on a boundary waits for the next one.
               if (accept) begin
                  pend_cmd <= i_wr_cmd;
                  pend_per <= i_wr_period;
                  state    <= PEND;
               end
            end
            PEND: begin
               if (fb) begin
                  state     <= IDLE;
                  frame_cnt <= '0;
                  case (pend_cmd)
                     2'b00:   o_palette <= 1'b0;
                     2'b01:   o_palette <= 1'b1;
                     2'b10:   o_palette <= ~o_palette;
                     default: period    <= pend_per;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
         // Auto-cycle only on boundaries where no command is applied.
         if (fb && (state == IDLE) && (period != '0)) begin
            if (frame_cnt == period - 1'b1) begin
               o_palette <= ~o_palette;
               frame_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule
